c3lib_tie_monitor: RTL and testbench
====================================

C3LIB_TIE_MONITOR -- requirements
Module: c3lib_tie_monitor

Interface
REQ-001 Parameter WIDTH, default 8; width of the monitored tie bus; legal range 1..64.
REQ-002 Parameter EXP_VAL, default {WIDTH{1'b1}}; expected static value of the tie bus.
REQ-003 Parameter SETTLE_CYC, default 4; cycles to wait after enable before monitoring starts; legal range 1..255.
REQ-004 Parameter DEBOUNCE, default 3; consecutive mismatch cycles needed to declare a fault; legal range 1..15.
REQ-005 Port clk, input, 1, the only clock; all flops on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port en, input, 1, monitor enable; level-sensitive.
REQ-008 Port tie_in, input, WIDTH, output of the tie cells under observation; static, synchronous to clk.
REQ-009 Port clr_req, input, 1, request to clear a latched fault; level-sensitive.
REQ-010 Port clr_ack, output, 1, single-cycle pulse acknowledging a fault clear.
REQ-011 Port armed, output, 1, high while the state is MONITOR.
REQ-012 Port fault, output, 1, high while the state is FAULT.
REQ-013 Port fault_vec, output, WIDTH, sticky per-bit record of which bits mismatched.
REQ-014 Port fault_cnt, output, 8, saturating count of entries into FAULT.

Function
REQ-015 The block SHALL implement the states IDLE, SETTLE, MONITOR and FAULT, and SHALL decode all outputs from registers only.
REQ-016 mism SHALL be defined as tie_in XOR EXP_VAL; the bus mismatches when mism is non-zero.
REQ-017 IDLE: when en=1, the next state SHALL be SETTLE with settle_cnt loaded to 0.
REQ-018 SETTLE: settle_cnt SHALL increment each cycle; the state SHALL move to MONITOR on the edge where settle_cnt==SETTLE_CYC-1, so armed rises exactly SETTLE_CYC cycles after the edge that first samples en=1 in IDLE.
REQ-019 In SETTLE and MONITOR, en=0 SHALL force IDLE on the next edge and clear settle_cnt and dbc; this rule takes priority over all other transitions.
REQ-020 MONITOR: the 4-bit debounce counter dbc SHALL increment on each edge that samples a mismatch, and SHALL be cleared on any edge that samples a match.
REQ-021 MONITOR: on the edge that samples a mismatch while dbc==DEBOUNCE-1, the state SHALL become FAULT, fault_vec SHALL load mism, fault_cnt SHALL increment (holding at 255), and dbc SHALL be cleared.
REQ-022 With DEBOUNCE=1, the first sampled mismatch in MONITOR SHALL enter FAULT on that same edge.
REQ-023 FAULT: fault_vec SHALL OR in mism each cycle; the state SHALL hold regardless of en.
REQ-024 FAULT with clr_req=1: on the next edge clr_ack SHALL pulse high for one cycle, fault_vec SHALL clear to 0, and the state SHALL become SETTLE if en=1 or IDLE if en=0.
REQ-025 When clr_req and an en change occur in the same cycle in FAULT, the state SHALL follow the en value sampled in that cycle.
REQ-026 clr_req outside FAULT SHALL be ignored; clr_ack SHALL remain 0.
REQ-027 A clr_req held high across the clear SHALL NOT produce a second clr_ack until FAULT is re-entered.
REQ-028 fault_cnt SHALL be cleared only by rst; it SHALL NOT be cleared by clr_req.

Reset
REQ-029 rst=1 sampled on an edge SHALL force IDLE; settle_cnt, dbc, fault_vec and fault_cnt SHALL clear to 0; clr_ack, armed and fault SHALL all be 0.
REQ-030 rst SHALL override every other input, including reset asserted mid-SETTLE, mid-debounce, or in FAULT during a clear.
REQ-031 After rst deasserts, the block SHALL require en to be sampled 1 in IDLE before leaving IDLE.

Verification
REQ-032 WIDTH=8 with defaults; rst, then en=1 with tie_in=8'hFF held -> armed rises on cycle 4 after en; fault stays 0 for 1000 cycles.
REQ-033 In MONITOR, tie_in=8'hFB for 3 cycles -> fault=1 after the 3rd edge; fault_vec=8'h04; fault_cnt=1.
REQ-034 In MONITOR, tie_in=8'hFE for 2 cycles, then 8'hFF for 1 cycle, then 8'hFE for 2 cycles -> fault stays 0 (dbc restarts).
REQ-035 In FAULT, tie_in alternates 8'h7F and 8'hFD, then clr_req=1 with en=1 -> fault_vec=8'h82 before the clear; one clr_ack pulse; fault_vec=0; armed returns 4 cycles after the clear.
REQ-036 en falls 2 cycles into SETTLE, and separately rst is pulsed in FAULT -> IDLE on the next edge in each case; rst additionally gives fault_cnt=0 and all outputs 0.
REQ-037 Run 300 fault/clear cycles -> fault_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/c3lib_tie_monitor.sv
// c3lib_tie_monitor: watches a static tie-cell bus against EXP_VAL
// Ports: clk, rst (sync high), en, tie_in, clr_req | clr_ack, armed, fault, fault_vec, fault_cnt
module c3lib_tie_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] EXP_VAL = {WIDTH{1'b1}},
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] tie_in,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             armed,
  output logic             fault,
  output logic [WIDTH-1:0] fault_vec,
  output logic [7:0]       fault_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MON,
    S_FAULT
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] DBC_LAST = 4'(DEBOUNCE - 1);

  state_t state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] dbc_q, dbc_d;
  logic [WIDTH-1:0] fault_vec_q, fault_vec_d;
  logic [7:0] fault_cnt_q, fault_cnt_d;
  logic clr_ack_q, clr_ack_d;
  logic [WIDTH-1:0] mism;

  assign mism = tie_in ^ EXP_VAL;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    dbc_d        = dbc_q;
    fault_vec_d  = fault_vec_q;
    fault_cnt_d  = fault_cnt_q;
    clr_ack_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d      = S_SETTLE;
          settle_cnt_d = 8'd0;
        end
      end
      S_SETTLE: begin
        if (!en) begin
          state_d      = S_IDLE;
          settle_cnt_d = 8'd0;
          dbc_d        = 4'd0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = S_MON;
          settle_cnt_d = 8'd0;
          dbc_d        = 4'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_MON: begin
        if (!en) begin
          state_d      = S_IDLE;
          settle_cnt_d = 8'd0;
          dbc_d        = 4'd0;
        end else if (|mism) begin
          if (dbc_q == DBC_LAST) begin
            state_d     = S_FAULT;
            fault_vec_d = mism;
            dbc_d       = 4'd0;
            if (fault_cnt_q != 8'hFF)
              fault_cnt_d = fault_cnt_q + 8'd1;
          end else begin
            dbc_d = dbc_q + 4'd1;
          end
        end else begin
          dbc_d = 4'd0;
        end
      end
      S_FAULT: begin
        if (clr_req) begin
          // en sampled alongside the clear picks the exit state
          clr_ack_d    = 1'b1;
          fault_vec_d  = '0;
          settle_cnt_d = 8'd0;
          dbc_d        = 4'd0;
          state_d      = en ? S_SETTLE : S_IDLE;
        end else begin
          fault_vec_d = fault_vec_q | mism;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 8'd0;
      dbc_q        <= 4'd0;
      fault_vec_q  <= '0;
      fault_cnt_q  <= 8'd0;
      clr_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      dbc_q        <= dbc_d;
      fault_vec_q  <= fault_vec_d;
      fault_cnt_q  <= fault_cnt_d;
      clr_ack_q    <= clr_ack_d;
    end
  end

  assign armed     = (state_q == S_MON);
  assign fault     = (state_q == S_FAULT);
  assign clr_ack   = clr_ack_q;
  assign fault_vec = fault_vec_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_c3lib_tie_monitor.sv
// tb_c3lib_tie_monitor: directed tests for c3lib_tie_monitor
// Defaults: WIDTH=8, EXP_VAL=8'hFF, SETTLE_CYC=4, DEBOUNCE=3
module tb_c3lib_tie_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] tie_in;
  logic       clr_req;
  logic       clr_ack;
  logic       armed;
  logic       fault;
  logic [7:0] fault_vec;
  logic [7:0] fault_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  c3lib_tie_monitor u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tie_in    (tie_in),
    .clr_req   (clr_req),
    .clr_ack   (clr_ack),
    .armed     (armed),
    .fault     (fault),
    .fault_vec (fault_vec),
    .fault_cnt (fault_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_byte(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // after the qualifying edge, expect armed low for n-1 edges then high
  task automatic wait_armed(string nm, int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk_bit(nm, armed, (i == n));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tie_in = 8'hFF; clr_req = 1'b0;
    step(); step();
    chk_bit("rst_armed", armed, 1'b0);
    chk_bit("rst_fault", fault, 1'b0);
    chk_bit("rst_ack", clr_ack, 1'b0);
    chk_byte("rst_vec", fault_vec, 8'h00);
    chk_byte("rst_cnt", fault_cnt, 8'h00);
    rst = 1'b0;
    step();
    chk_bit("idle_no_en", armed, 1'b0);
  endtask

  task automatic test_settle();
    int seen;
    en = 1'b1;
    step();
    chk_bit("settle_e0", armed, 1'b0);
    wait_armed("settle_arm", 4);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (fault !== 1'b0 || armed !== 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL quiet_1000: got %0d bad cycles want 0", seen);
    end
  endtask

  task automatic test_fault();
    tie_in = 8'hFB;
    step(); chk_bit("fb_1", fault, 1'b0);
    step(); chk_bit("fb_2", fault, 1'b0);
    step(); chk_bit("fb_3", fault, 1'b1);
    chk_byte("fb_vec", fault_vec, 8'h04);
    chk_byte("fb_cnt", fault_cnt, 8'd1);
    chk_bit("fb_armed", armed, 1'b0);
    en = 1'b0; tie_in = 8'hFF;
    step(); step();
    chk_bit("fault_hold", fault, 1'b1);
    en = 1'b1;
  endtask

  task automatic test_clear();
    clr_req = 1'b1;
    step();
    chk_bit("clr_ack1", clr_ack, 1'b1);
    chk_bit("clr_fault", fault, 1'b0);
    chk_byte("clr_vec", fault_vec, 8'h00);
    chk_byte("clr_cnt", fault_cnt, 8'd1);
    step();
    chk_bit("clr_ack_once", clr_ack, 1'b0);
    clr_req = 1'b0;
    step(); chk_bit("clr_arm2", armed, 1'b0);
    step(); chk_bit("clr_arm3", armed, 1'b0);
    step(); chk_bit("clr_arm4", armed, 1'b1);
  endtask

  task automatic test_debounce();
    logic [7:0] pat [6];
    pat[0] = 8'hFE; pat[1] = 8'hFE; pat[2] = 8'hFF;
    pat[3] = 8'hFE; pat[4] = 8'hFE; pat[5] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tie_in = pat[i];
      step();
      chk_bit("dbc_restart", fault, 1'b0);
    end
  endtask

  task automatic test_accum();
    tie_in = 8'h7F;
    step(); step(); step();
    chk_bit("acc_fault", fault, 1'b1);
    chk_byte("acc_vec0", fault_vec, 8'h80);
    chk_byte("acc_cnt", fault_cnt, 8'd2);
    tie_in = 8'hFD; step();
    tie_in = 8'h7F; step();
    tie_in = 8'hFD; step();
    chk_byte("acc_vec", fault_vec, 8'h82);
    tie_in = 8'hFF; clr_req = 1'b1;
    step();
    chk_bit("acc_ack", clr_ack, 1'b1);
    chk_byte("acc_vec_clr", fault_vec, 8'h00);
    clr_req = 1'b0;
    step(); chk_bit("acc_ack_off", clr_ack, 1'b0);
    step(); step();
    step(); chk_bit("acc_rearm", armed, 1'b1);
  endtask

  task automatic test_ignore_clr();
    clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bit("ign_ack", clr_ack, 1'b0);
      chk_bit("ign_armed", armed, 1'b1);
    end
    clr_req = 1'b0;
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    step();
    chk_bit("mon_en0", armed, 1'b0);
    en = 1'b1;
    step(); step(); step();
    en = 1'b0;
    step();
    step();
    chk_bit("settle_en0", armed, 1'b0);
    en = 1'b1;
    step();
    wait_armed("resettle", 4);
  endtask

  task automatic test_rst_fault();
    tie_in = 8'hFB;
    step(); step(); step();
    chk_bit("rf_fault", fault, 1'b1);
    tie_in = 8'hFF; clr_req = 1'b1; rst = 1'b1;
    step();
    chk_bit("rf_ack", clr_ack, 1'b0);
    chk_bit("rf_fault0", fault, 1'b0);
    chk_bit("rf_armed", armed, 1'b0);
    chk_byte("rf_vec", fault_vec, 8'h00);
    chk_byte("rf_cnt", fault_cnt, 8'h00);
    rst = 1'b0; clr_req = 1'b0;
    step();
    wait_armed("rf_rearm", 4);
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 300; i++) begin
      tie_in = 8'hFE;
      step(); step(); step();
      if (i == 100) chk_byte("sat_100", fault_cnt, 8'd100);
      if (i == 255) chk_byte("sat_255", fault_cnt, 8'd255);
      tie_in = 8'hFF; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      step(); step(); step(); step();
    end
    chk_byte("sat_end", fault_cnt, 8'd255);
    chk_bit("sat_armed", armed, 1'b1);
  endtask

  initial begin
    test_reset();
    test_settle();
    test_fault();
    test_clear();
    test_debounce();
    test_accum();
    test_ignore_clr();
    test_en_drop();
    test_rst_fault();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
